// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide engine: radix-2 Booth multiply and restoring
// divide on magnitudes, one step per clock, results presented on hi/lo.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_done,
  output logic             div_done,
  output logic             div_zero,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for start_mult / start_div
  // MULT  | Booth steps, one per edge
  // DIV   | restoring divide steps, one quotient bit per edge
  // DONE  | hi/lo hold the fresh result, matching done flag high
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic             q_m1;
  logic             op_mult;
  logic             sign_a;
  logic             neg_q;
  logic             div_zero_q;

  logic             steps_done;
  logic             b_is_zero;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] quo_signed, rem_signed;

  assign steps_done = (count == CW'(WIDTH));
  assign b_is_zero  = (b == '0);
  assign a_abs      = a[WIDTH-1] ? -a : a;
  assign b_abs      = b[WIDTH-1] ? -b : b;

  // Accumulator carries one guard bit so subtracting the most negative M cannot overflow.
  assign m_ext = {m_reg[WIDTH-1], m_reg};

  always_comb begin
    booth_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  assign div_shift  = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, m_reg};
  assign quo_signed = neg_q  ? -q_reg : q_reg;
  assign rem_signed = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_mult)                  state_nxt = MULT;
        else if (start_div && !b_is_zero) state_nxt = DIV;
      end
      MULT:    if (steps_done) state_nxt = DONE;
      DIV:     if (steps_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mult_done = (state == DONE) &&  op_mult;
    div_done  = (state == DONE) && !op_mult;
    div_zero  = div_zero_q;
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      count      <= '0;
      acc        <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      q_m1       <= 1'b0;
      op_mult    <= 1'b0;
      sign_a     <= 1'b0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      div_zero_q <= (state == IDLE) && start_div && !start_mult && b_is_zero;
      case (state)
        IDLE: begin
          if (start_mult) begin
            acc     <= '0;
            q_reg   <= b;
            m_reg   <= a;
            q_m1    <= 1'b0;
            count   <= '0;
            op_mult <= 1'b1;
          end else if (start_div && !b_is_zero) begin
            acc     <= '0;
            q_reg   <= a_abs;
            m_reg   <= b_abs;
            sign_a  <= a[WIDTH-1];
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            count   <= '0;
            op_mult <= 1'b0;
          end
        end
        MULT: begin
          if (steps_done) begin
            hi <= acc[WIDTH-1:0];
            lo <= q_reg;
          end else begin
            acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_reg <= {booth_sum[0], q_reg[WIDTH-1:1]};
            q_m1  <= q_reg[0];
            count <= count + 1'b1;
          end
        end
        DIV: begin
          if (steps_done) begin
            hi <= rem_signed;
            lo <= quo_signed;
          end else begin
            // Negative trial means the divisor did not fit: keep the shifted remainder.
            if (div_trial[WIDTH]) begin
              acc   <= div_shift;
              q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end else begin
              acc   <= div_trial;
              q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            end
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products/quotients, latency,
// divide-by-zero, busy-ignore and asynchronous reset abort.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset_in;
  logic         start_mult;
  logic         start_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         mult_done;
  logic         div_done;
  logic         div_zero;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .mult_done  (mult_done),
    .div_done   (div_done),
    .div_zero   (div_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at a negedge, scramble operands after the start edge, check timing and result.
  task automatic do_op(input string tag, input logic sm, input logic sd,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    a = av;
    b = bv;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = $urandom;
    b = $urandom;
    chk({tag, " busy_started"}, busy, 1'b1);
    repeat (W) @(negedge clk);
    chk({tag, " early_done"}, {mult_done, div_done}, 2'b00);
    chk({tag, " hi_held"}, hi, prev_hi);
    chk({tag, " lo_held"}, lo, prev_lo);
    @(negedge clk);
    chk({tag, " mult_done"}, mult_done, sm);
    chk({tag, " div_done"}, div_done, sd && !sm);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    chk({tag, " done_cleared"}, {mult_done, div_done}, 2'b00);
    chk({tag, " busy_cleared"}, busy, 1'b0);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    int done_seen;
    reset_in   = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_flags", {mult_done, div_done, div_zero, busy}, 4'b0000);
    reset_in = 1'b1;

    do_op("mul_7x-3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mul_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    do_op("mul_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);

    @(negedge clk);
    start_div = 1'b1;
    a = 32'd100;
    b = 32'd0;
    @(negedge clk);
    start_div = 1'b0;
    chk("dz_pulse", div_zero, 1'b1);
    chk("dz_busy", busy, 1'b0);
    chk("dz_hi", hi, prev_hi);
    chk("dz_lo", lo, prev_lo);
    @(negedge clk);
    chk("dz_one_cycle", div_zero, 1'b0);
    done_seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (div_done || mult_done || busy) done_seen++;
    end
    chk("dz_no_done", done_seen, 0);

    do_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    do_op("both_starts", 1'b1, 1'b1, 32'd6, 32'd4, 32'd0, 32'd24);

    @(negedge clk);
    start_mult = 1'b1;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    start_mult = 1'b0;
    repeat (4) @(negedge clk);
    start_div = 1'b1;
    a = 32'd50;
    b = 32'd5;
    @(negedge clk);
    start_div = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    #2 reset_in = 1'b0;
    #1;
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    chk("abort_flags", {mult_done, div_done, div_zero, busy}, 4'b0000);
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    done_seen = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (div_done || mult_done || busy) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    prev_hi = '0;
    prev_lo = '0;

    do_op("mul_3x5", 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
